// File: rtl/avaliador_jogada.sv
// Move judge: opens a response window per note, compares the first new press
// against the target lane and emits a single-cycle acertou or errou pulse.
module avaliador_jogada #(
   parameter int N_BOTOES    = 8,
   parameter int JANELA_BASE = 64,
   parameter int PASSO       = 8,
   parameter int JANELA_MIN  = 4,
   parameter int LARGURA_T   = 7
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 iniciar,
   input  logic                 nota_valida,
   input  logic [2:0]           nota_alvo,
   input  logic [N_BOTOES-1:0]  botoes,
   input  logic [2:0]           linhas_bloq,
   output logic                 acertou,
   output logic                 errou,
   output logic                 enable_pontos,
   output logic                 janela_aberta,
   output logic [LARGURA_T-1:0] tempo_restante,
   output logic [1:0]           estado_o
);

   typedef enum logic [1:0] {
      INATIVO     = 2'd0,
      ESPERA_NOTA = 2'd1,
      JANELA      = 2'd2,
      RESULTADO   = 2'd3
   } estado_t;

   localparam logic [LARGURA_T-1:0] UM = LARGURA_T'(1);

   estado_t              estado_q;
   logic [2:0]           alvo_q;
   logic [N_BOTOES-1:0]  botoes_q;
   logic [LARGURA_T-1:0] tempo_q;
   logic                 acertou_q;
   logic                 errou_q;

   logic [N_BOTOES-1:0]  press;
   logic [N_BOTOES-1:0]  alvo_onehot;
   logic [LARGURA_T-1:0] janela_len;
   int                   janela_calc;

   // A target lane outside the button range decodes to all zeros, so any press is wrong.
   always_comb begin
      press       = botoes & ~botoes_q;
      alvo_onehot = '0;
      for (int i = 0; i < N_BOTOES; i++) begin
         alvo_onehot[i] = (int'(alvo_q) == i);
      end
   end

   // Signed arithmetic so a large blocking count clamps instead of wrapping.
   always_comb begin
      janela_calc = JANELA_BASE - int'(linhas_bloq) * PASSO;
      if (janela_calc < JANELA_MIN) begin
         janela_calc = JANELA_MIN;
      end
      janela_len = janela_calc[LARGURA_T-1:0];
   end

   always_ff @(posedge clock) begin
      botoes_q <= botoes;
      if (reset) begin
         estado_q  <= INATIVO;
         alvo_q    <= '0;
         tempo_q   <= '0;
         acertou_q <= 1'b0;
         errou_q   <= 1'b0;
         botoes_q  <= '0;
      end else if (!iniciar) begin
         estado_q  <= INATIVO;
         tempo_q   <= '0;
         acertou_q <= 1'b0;
         errou_q   <= 1'b0;
      end else begin
         acertou_q <= 1'b0;
         errou_q   <= 1'b0;
         case (estado_q)
            INATIVO: begin
               estado_q <= ESPERA_NOTA;
            end
            ESPERA_NOTA: begin
               if (nota_valida) begin
                  estado_q <= JANELA;
                  alvo_q   <= nota_alvo;
                  tempo_q  <= janela_len;
               end
            end
            JANELA: begin
               // A press on the last window cycle beats the timeout.
               if (press != '0 && press == alvo_onehot) begin
                  acertou_q <= 1'b1;
                  tempo_q   <= '0;
                  estado_q  <= RESULTADO;
               end else if (press != '0 || tempo_q == UM) begin
                  errou_q  <= 1'b1;
                  tempo_q  <= '0;
                  estado_q <= RESULTADO;
               end else begin
                  tempo_q <= tempo_q - UM;
               end
            end
            RESULTADO: begin
               tempo_q  <= '0;
               estado_q <= ESPERA_NOTA;
            end
            default: begin
               estado_q <= INATIVO;
            end
         endcase
      end
   end

   assign acertou        = acertou_q;
   assign errou          = errou_q;
   assign enable_pontos  = (estado_q != INATIVO);
   assign janela_aberta  = (estado_q == JANELA);
   assign tempo_restante = tempo_q;
   assign estado_o       = estado_q;

endmodule
